scalar_wb_unit: RTL and testbench

Scalar writeback stage sitting directly upstream of the 8-entry × 16-bit scalar register file. It merges results from the single-cycle scalar ALU and the variable-latency memory load path. Its registered write port (`wr_en`, `wr_dst`, `wr_data`) drives the register file. It also keeps a per-register pending scoreboard for the issue stage and, optionally, a bypass path for the operand reads.

---
 rtl/scalar_wb_unit.sv | 134 +++++++++++++
 tb/tb_scalar_wb_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_wb_unit.sv
// Scalar writeback stage: merges ALU and queued load results into one register-file write port.
// Optional operand bypass from the registered write port is compiled in with `define SCALAR_WB_BYPASS_EN.
module scalar_wb_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_dst,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_dst,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dst,
  output logic [(1<<ADDR_W)-1:0]   pend,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_dst,
  output logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        byp_addr_1,
  input  logic [ADDR_W-1:0]        byp_addr_2,
  output logic                     byp_hit_1,
  output logic                     byp_hit_2,
  output logic [DATA_W-1:0]        byp_data_1,
  output logic [DATA_W-1:0]        byp_data_2
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QDEPTH);

  logic [ADDR_W-1:0] r_q_dst  [QDEPTH];
  logic [DATA_W-1:0] r_q_data [QDEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_dst;
  logic [DATA_W-1:0] r_wr_data;
  logic [NREG-1:0]   r_pend;

  logic              w_mem_ready, w_accept, w_q_empty;
  logic              w_sel_en, w_enq, w_deq;
  logic [ADDR_W-1:0] w_sel_dst;
  logic [DATA_W-1:0] w_sel_data;
  logic [NREG-1:0]   w_set, w_clr;

  // Ready depends only on occupancy so the load path never sees ALU activity.
  assign w_mem_ready = (r_count != FULL_CNT);
  assign w_accept    = mem_valid && w_mem_ready;
  assign w_q_empty   = (r_count == '0);

  always_comb begin
    w_sel_en   = 1'b0;
    w_sel_dst  = alu_dst;
    w_sel_data = alu_data;
    w_enq      = 1'b0;
    w_deq      = 1'b0;
    if (alu_valid) begin
      w_sel_en = 1'b1;
      w_enq    = w_accept;
    end else if (!w_q_empty) begin
      w_sel_en   = 1'b1;
      w_sel_dst  = r_q_dst[r_rd_ptr];
      w_sel_data = r_q_data[r_rd_ptr];
      w_deq      = 1'b1;
      w_enq      = w_accept;
    end else if (w_accept) begin
      w_sel_en   = 1'b1;
      w_sel_dst  = mem_dst;
      w_sel_data = mem_data;
    end
  end

  assign w_set = issue_valid ? (NREG'(1) << issue_dst) : '0;
  assign w_clr = w_sel_en    ? (NREG'(1) << w_sel_dst) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_dst  <= '0;
      r_wr_data <= '0;
      r_pend    <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_wr_en <= w_sel_en;
      if (w_sel_en) begin
        r_wr_dst  <= w_sel_dst;
        r_wr_data <= w_sel_data;
      end
      // A new issue to a register outranks its retiring write in the same cycle.
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_dst[r_wr_ptr]  <= mem_dst;
      r_q_data[r_wr_ptr] <= mem_data;
    end
  end

  assign mem_ready = w_mem_ready;
  assign pend      = r_pend;
  assign wr_en     = r_wr_en;
  assign wr_dst    = r_wr_dst;
  assign wr_data   = r_wr_data;

`ifdef SCALAR_WB_BYPASS_EN
  assign byp_hit_1  = r_wr_en && (byp_addr_1 == r_wr_dst);
  assign byp_hit_2  = r_wr_en && (byp_addr_2 == r_wr_dst);
  assign byp_data_1 = byp_hit_1 ? r_wr_data : '0;
  assign byp_data_2 = byp_hit_2 ? r_wr_data : '0;
`else
  logic w_unused_byp;
  assign w_unused_byp = ^{byp_addr_1, byp_addr_2};
  assign byp_hit_1  = 1'b0;
  assign byp_hit_2  = 1'b0;
  assign byp_data_1 = '0;
  assign byp_data_2 = '0;
`endif

endmodule

// File: tb/tb_scalar_wb_unit.sv
// Directed self-checking bench for scalar_wb_unit: reset, ALU, direct load, contention,
// queue-full back-pressure, scoreboard set-wins, mid-operation reset and bypass.
module tb_scalar_wb_unit;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int QDEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, mem_valid, issue_valid;
  logic [ADDR_W-1:0] alu_dst, mem_dst, issue_dst, byp_addr_1, byp_addr_2;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              mem_ready, wr_en, byp_hit_1, byp_hit_2;
  logic [7:0]        pend;
  logic [ADDR_W-1:0] wr_dst;
  logic [DATA_W-1:0] wr_data, byp_data_1, byp_data_2;

  int checks = 0;
  int errors = 0;

  scalar_wb_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .pend(pend),
    .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data),
    .byp_addr_1(byp_addr_1), .byp_addr_2(byp_addr_2),
    .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
    .byp_data_1(byp_data_1), .byp_data_2(byp_data_2)
  );

  always #5 clk = ~clk;

  // Upstream guarantee: never issue to a register that is still pending.
  always @(negedge clk) begin
    if (!rst && issue_valid && pend[issue_dst]) begin
      errors++;
      $display("FAIL issue_guard: issue to pending r%0d pend=%h", issue_dst, pend);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_dst = 0; alu_data = 0;
    mem_valid = 0; mem_dst = 0; mem_data = 0;
    issue_valid = 0; issue_dst = 0;
    byp_addr_1 = 0; byp_addr_2 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick(); tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b exp 0", wr_en); end
    checks++; if (wr_dst !== 3'd0) begin errors++; $display("FAIL rst_wr_dst got %h exp 0", wr_dst); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL rst_wr_data got %h exp 0", wr_data); end
    checks++; if (byp_hit_1 !== 1'b0) begin errors++; $display("FAIL rst_byp_hit got %b exp 0", byp_hit_1); end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (wr_en !== 1'b0 || pend !== 8'h00 || mem_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_%0d got wr_en=%b pend=%h rdy=%b exp 0/00/1", i, wr_en, pend, mem_ready);
      end
    end
  endtask

  task automatic test_alu_only();
    issue_valid = 1; issue_dst = 3;
    tick();
    issue_valid = 0;
    checks++; if (pend !== 8'h08) begin errors++; $display("FAIL alu_pend_set got %h exp 08", pend); end
    alu_valid = 1; alu_dst = 3; alu_data = 16'hBEEF;
    tick();
    alu_valid = 0;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL alu_wr_en got %b exp 1", wr_en); end
    checks++; if (wr_dst !== 3'd3) begin errors++; $display("FAIL alu_wr_dst got %h exp 3", wr_dst); end
    checks++; if (wr_data !== 16'hBEEF) begin errors++; $display("FAIL alu_wr_data got %h exp beef", wr_data); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL alu_pend_clr got %h exp 00", pend); end
    byp_addr_1 = 3; byp_addr_2 = 2;
    #1;
`ifdef SCALAR_WB_BYPASS_EN
    checks++; if (byp_hit_1 !== 1'b1) begin errors++; $display("FAIL byp_hit_1 got %b exp 1", byp_hit_1); end
    checks++; if (byp_data_1 !== 16'hBEEF) begin errors++; $display("FAIL byp_data_1 got %h exp beef", byp_data_1); end
`else
    checks++; if (byp_hit_1 !== 1'b0) begin errors++; $display("FAIL byp_hit_1 got %b exp 0", byp_hit_1); end
    checks++; if (byp_data_1 !== 16'h0) begin errors++; $display("FAIL byp_data_1 got %h exp 0", byp_data_1); end
`endif
    checks++; if (byp_hit_2 !== 1'b0 || byp_data_2 !== 16'h0) begin errors++; $display("FAIL byp_miss_2 got %b/%h exp 0/0", byp_hit_2, byp_data_2); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL alu_idle_wr_en got %b exp 0", wr_en); end
    checks++; if (wr_dst !== 3'd3 || wr_data !== 16'hBEEF) begin errors++; $display("FAIL alu_hold got %h/%h exp 3/beef", wr_dst, wr_data); end
    checks++; if (byp_hit_1 !== 1'b0) begin errors++; $display("FAIL byp_idle got %b exp 0", byp_hit_1); end
    byp_addr_1 = 0; byp_addr_2 = 0;
  endtask

  task automatic test_direct_load();
    mem_valid = 1; mem_dst = 4; mem_data = 16'h1234;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL dl_ready got %b exp 1", mem_ready); end
    tick();
    mem_valid = 0;
    checks++; if (wr_en !== 1'b1 || wr_dst !== 3'd4 || wr_data !== 16'h1234) begin errors++; $display("FAIL dl_write got %b/%h/%h exp 1/4/1234", wr_en, wr_dst, wr_data); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL dl_no_requeue got %b exp 0", wr_en); end
  endtask

  task automatic test_contention();
    issue_valid = 1; issue_dst = 1;
    tick();
    issue_dst = 2;
    tick();
    issue_valid = 0;
    checks++; if (pend !== 8'h06) begin errors++; $display("FAIL ct_pend got %h exp 06", pend); end
    alu_valid = 1; alu_dst = 1; alu_data = 16'h0001;
    mem_valid = 1; mem_dst = 2; mem_data = 16'h0002;
    tick();
    alu_valid = 0; mem_valid = 0;
    checks++; if (wr_en !== 1'b1 || wr_dst !== 3'd1 || wr_data !== 16'h0001) begin errors++; $display("FAIL ct_first got %b/%h/%h exp 1/1/0001", wr_en, wr_dst, wr_data); end
    checks++; if (pend !== 8'h04) begin errors++; $display("FAIL ct_pend1 got %h exp 04", pend); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_dst !== 3'd2 || wr_data !== 16'h0002) begin errors++; $display("FAIL ct_second got %b/%h/%h exp 1/2/0002", wr_en, wr_dst, wr_data); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL ct_pend2 got %h exp 00", pend); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL ct_drained got %b exp 0", wr_en); end
  endtask

  // ALU busy cycles 0..5; loads 0..5 offered and held until accepted.
  task automatic test_queue_full();
    logic [12:0] exp_rdy;
    logic        e_en;
    logic [2:0]  e_dst;
    logic [15:0] e_data;
    int          li;
    exp_rdy = 13'b1111110001111;
    li = 0;
    for (int c = 0; c < 13; c++) begin
      alu_valid = (c < 6); alu_dst = 6; alu_data = 16'hA000 + 16'(c);
      mem_valid = (li < 6); mem_dst = 3'(li); mem_data = 16'h0100 + 16'(li);
      #1;
      checks++; if (mem_ready !== exp_rdy[c]) begin errors++; $display("FAIL qf_ready_c%0d got %b exp %b", c, mem_ready, exp_rdy[c]); end
      if (mem_valid && exp_rdy[c]) li++;
      tick();
      if (c < 6) begin
        e_en = 1; e_dst = 3'd6; e_data = 16'hA000 + 16'(c);
      end else if (c < 12) begin
        e_en = 1; e_dst = 3'(c - 6); e_data = 16'h0100 + 16'(c - 6);
      end else begin
        e_en = 0; e_dst = wr_dst; e_data = wr_data;
      end
      checks++;
      if (wr_en !== e_en || (e_en && (wr_dst !== e_dst || wr_data !== e_data))) begin
        errors++;
        $display("FAIL qf_write_c%0d got %b/%h/%h exp %b/%h/%h", c, wr_en, wr_dst, wr_data, e_en, e_dst, e_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard_set_wins();
    alu_valid = 1; alu_dst = 5; alu_data = 16'h5555;
    issue_valid = 1; issue_dst = 5;
    tick();
    issue_valid = 0;
    checks++; if (wr_en !== 1'b1 || wr_dst !== 3'd5) begin errors++; $display("FAIL sb_write got %b/%h exp 1/5", wr_en, wr_dst); end
    checks++; if (pend !== 8'h20) begin errors++; $display("FAIL sb_set_wins got %h exp 20", pend); end
    alu_data = 16'h6666;
    tick();
    alu_valid = 0;
    checks++; if (pend !== 8'h00 || wr_data !== 16'h6666) begin errors++; $display("FAIL sb_clear got %h/%h exp 00/6666", pend, wr_data); end
  endtask

  task automatic test_reset_mid_op();
    issue_valid = 1; issue_dst = 7;
    alu_valid = 1; alu_dst = 0; alu_data = 16'h1111;
    mem_valid = 1; mem_dst = 7; mem_data = 16'h7777;
    tick();
    issue_valid = 0;
    mem_dst = 6;
    tick();
    checks++; if (pend !== 8'h80) begin errors++; $display("FAIL mr_pend_before got %h exp 80", pend); end
    rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    checks++; if (wr_en !== 1'b0 || pend !== 8'h00 || mem_ready !== 1'b1) begin errors++; $display("FAIL mr_reset got %b/%h/%b exp 0/00/1", wr_en, pend, mem_ready); end
    checks++; if (wr_dst !== 3'd0 || wr_data !== 16'h0) begin errors++; $display("FAIL mr_reset_port got %h/%h exp 0/0", wr_dst, wr_data); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mr_queue_discarded got %b exp 0", wr_en); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_dst = 3'(i + 1); alu_data = 16'hC000 + 16'(i);
      tick();
      checks++;
      if (wr_en !== 1'b1 || wr_dst !== 3'(i + 1) || wr_data !== 16'hC000 + 16'(i)) begin
        errors++;
        $display("FAIL b2b_%0d got %b/%h/%h exp 1/%h/%h", i, wr_en, wr_dst, wr_data, 3'(i + 1), 16'hC000 + 16'(i));
      end
    end
    alu_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_direct_load();
    test_contention();
    test_queue_full();
    test_scoreboard_set_wins();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
